audio_adc_rx: RTL and testbench

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

---
 rtl/audio_adc_rx.sv | 151 +++++++++++++++
 tb/tb_audio_adc_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: samples the codec's BCLK/LRCK/DATA as data in the clk domain
// and publishes one left/right sample pair per complete frame.
module audio_adc_rx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aud_bclk,
    input  logic              aud_adclrck,
    input  logic              aud_adcdat,
    output logic [DATA_W-1:0] left_sample,
    output logic [DATA_W-1:0] right_sample,
    output logic              sample_valid,
    output logic              frame_error
);
    // state | meaning
    // IDLE  | waiting for an LRCK fall (start of a left channel)
    // DELAY | discarding the I2S one-bit delay slot
    // SHIFT | capturing DATA_W bits, MSB first
    // HOLD  | ignoring trailing slot bits until the next LRCK edge
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic r_lrck_s1, r_lrck_s2, r_lrck_d;
    logic r_dat_s1, r_dat_s2;

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_left_hold;
    logic              r_left_ok;
    logic              r_chan_right;
    logic              r_valid_pend;

    logic              w_bclk_rise, w_lrck_edge, w_lrck_fall;
    logic              w_start, w_err, w_shift, w_done;
    logic [DATA_W-1:0] w_shift_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_d  <= 1'b0;
            r_lrck_s1 <= 1'b0;
            r_lrck_s2 <= 1'b0;
            r_lrck_d  <= 1'b0;
            r_dat_s1  <= 1'b0;
            r_dat_s2  <= 1'b0;
        end else begin
            r_bclk_s1 <= aud_bclk;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_d  <= r_bclk_s2;
            r_lrck_s1 <= aud_adclrck;
            r_lrck_s2 <= r_lrck_s1;
            r_lrck_d  <= r_lrck_s2;
            r_dat_s1  <= aud_adcdat;
            r_dat_s2  <= r_dat_s1;
        end
    end

    assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_d;
    assign w_lrck_edge  = r_lrck_s2 ^ r_lrck_d;
    assign w_lrck_fall  = r_lrck_d & ~r_lrck_s2;
    assign w_shift_next = {r_shift[DATA_W-2:0], r_dat_s2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A BCLK rise coincident with the LRCK edge is the delay slot, so skip DELAY.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_lrck_fall) w_state_nxt = w_bclk_rise ? S_SHIFT : S_DELAY;
            S_DELAY: begin
                if (w_lrck_edge)      w_state_nxt = S_IDLE;
                else if (w_bclk_rise) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_lrck_edge) w_state_nxt = S_IDLE;
                else if (w_bclk_rise && r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = S_HOLD;
            end
            S_HOLD:  if (w_lrck_edge) w_state_nxt = w_bclk_rise ? S_SHIFT : S_DELAY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_err   = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            S_IDLE:  w_start = w_lrck_fall;
            S_DELAY: w_err   = w_lrck_edge;
            S_SHIFT: begin
                w_err   = w_lrck_edge;
                w_shift = ~w_lrck_edge & w_bclk_rise;
            end
            S_HOLD:  w_start = w_lrck_edge;
            default: ;
        endcase
        w_done = w_shift && (r_cnt == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_left_ok    <= 1'b0;
            r_chan_right <= 1'b0;
            r_valid_pend <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            r_valid_pend <= 1'b0;
            sample_valid <= r_valid_pend;
            frame_error  <= w_err;
            if (w_start || w_err) r_cnt <= '0;
            else if (w_shift)     r_cnt <= r_cnt + CNT_W'(1);
            if (w_start) r_chan_right <= r_lrck_s2;
            if (w_shift) r_shift <= w_shift_next;
            if (w_err) r_left_ok <= 1'b0;
            if (w_done) begin
                if (!r_chan_right) begin
                    r_left_hold <= w_shift_next;
                    r_left_ok   <= 1'b1;
                end else begin
                    r_left_ok <= 1'b0;
                    if (r_left_ok) begin
                        left_sample  <= r_left_hold;
                        right_sample <= w_shift_next;
                        r_valid_pend <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: drives I2S frames at BCLK = clk/16, predicts the
// sample pairs and frame errors at channel level and checks them from a monitor.
module tb_audio_adc_rx;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bclk = 1'b0;
    logic          lrck = 1'b1;
    logic          dat = 1'b0;
    logic [DW-1:0] left_sample, right_sample;
    logic          sample_valid, frame_error;

    always #5 clk = ~clk;

    audio_adc_rx #(.DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .aud_bclk     (bclk),
        .aud_adclrck  (lrck),
        .aud_adcdat   (dat),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .frame_error  (frame_error)
    );

    typedef struct {
        bit            is_err;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Channel-level reference: capture arms on an LRCK fall, a short captured
    // channel becomes an error at the next edge, a full right after a full left is a pair.
    bit            m_cap = 1'b0;
    bit            m_have_left = 1'b0;
    bit            m_last_short = 1'b0;
    bit            m_prev_lr = 1'b1;
    logic [DW-1:0] m_held = '0;

    task automatic model_channel(input bit lr, input logic [DW-1:0] val, input int nbits);
        exp_t e;
        bit   edge_seen;
        edge_seen = (lr != m_prev_lr);
        m_prev_lr = lr;
        if (!edge_seen) return;
        if (m_cap && m_last_short) begin
            e.is_err = 1'b1; e.l = '0; e.r = '0;
            q.push_back(e);
            m_cap = 1'b0; m_have_left = 1'b0; m_last_short = 1'b0;
            return;
        end
        if (!m_cap && lr == 1'b0) begin
            m_cap = 1'b1;
            m_last_short = 1'b0;
            m_have_left = 1'b0;
        end
        if (!m_cap) return;
        m_last_short = (nbits < DW);
        if (nbits >= DW) begin
            if (lr == 1'b0) begin
                m_held = val;
                m_have_left = 1'b1;
            end else begin
                if (m_have_left) begin
                    e.is_err = 1'b0; e.l = m_held; e.r = val;
                    q.push_back(e);
                end
                m_have_left = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_cap = 1'b0; m_have_left = 1'b0; m_last_short = 1'b0;
        m_prev_lr = lrck;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One BCLK period: data and (normally) LRCK change on the falling edge.
    task automatic slot(input bit lr, input bit d, input bit align);
        @(negedge clk);
        bclk = 1'b0;
        dat  = d;
        if (!align) lrck = lr;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        if (align) lrck = lr;
        repeat (7) @(negedge clk);
    endtask

    task automatic channel(input bit lr, input logic [DW-1:0] val, input int nbits, input bit align);
        int last;
        model_channel(lr, val, nbits);
        last = (nbits >= DW) ? 31 : nbits;
        for (int s = 0; s <= last; s++) begin
            bit d;
            d = 1'($urandom_range(0, 1));
            if (s >= 1 && s <= DW) d = val[DW - s];
            slot(lr, d, (s == 0) && align);
        end
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit align);
        channel(1'b0, l, DW, align);
        channel(1'b1, r, DW, align);
    endtask

    logic [DW-1:0] p_l, p_r;
    bit            chg = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chg = 1'b0;
        end else begin
            if (chg) begin
                total++;
                if (!sample_valid) begin
                    bad++;
                    $display("FAIL stable: outputs changed (l=%0h r=%0h) with no sample_valid after", left_sample, right_sample);
                end
                chg = 1'b0;
            end
            if (left_sample !== p_l || right_sample !== p_r) chg = 1'b1;
            if (sample_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL valid: unexpected pulse l=%0h r=%0h, none expected", left_sample, right_sample);
                end else begin
                    e = q.pop_front();
                    if (e.is_err || frame_error || left_sample !== e.l || right_sample !== e.r) begin
                        bad++;
                        $display("FAIL pair: got l=%0h r=%0h err=%0b, want l=%0h r=%0h err_expected=%0b",
                                 left_sample, right_sample, frame_error, e.l, e.r, e.is_err);
                    end
                end
            end else if (frame_error) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_error: unexpected pulse, none expected");
                end else begin
                    e = q.pop_front();
                    if (!e.is_err) begin
                        bad++;
                        $display("FAIL frame_error: got error pulse, want pair l=%0h r=%0h", e.l, e.r);
                    end
                end
            end
        end
        p_l = left_sample;
        p_r = right_sample;
    end

    initial begin
        logic [DW-1:0] a, b;
        int            n;
        rst = 1'b1; lrck = 1'b1; bclk = 1'b0; dat = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left", 32'(left_sample), 32'h0);
        check("rst_right", 32'(right_sample), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_err", 32'(frame_error), 32'h0);
        rst = 1'b0;

        // Right channel first is ignored, then a basic frame.
        a = 16'($urandom);
        channel(1'b1, a, DW, 1'b0);
        frame(16'hA5C3, 16'h7FFF, 1'b0);

        frame(16'h8000, 16'h0001, 1'b0);
        frame(16'h1234, 16'hFEDC, 1'b0);
        frame(16'h0000, 16'hFFFF, 1'b0);

        // Right channel cut after 10 bits, recovery frame.
        channel(1'b0, 16'h1111, DW, 1'b0);
        channel(1'b1, 16'h2222, 10, 1'b0);
        frame(16'h0F0F, 16'hF0F0, 1'b0);
        frame(16'h5555, 16'hAAAA, 1'b0);

        // Reset in the middle of a left channel.
        fork
            channel(1'b0, 16'h1357, DW, 1'b0);
            begin
                repeat (200) @(negedge clk);
                rst = 1'b1;
                #1;
                check("midrst_left", 32'(left_sample), 32'h0);
                check("midrst_right", 32'(right_sample), 32'h0);
                check("midrst_valid", 32'(sample_valid), 32'h0);
                check("midrst_err", 32'(frame_error), 32'h0);
                model_reset();
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        a = 16'($urandom);
        channel(1'b1, a, DW, 1'b0);
        frame(16'h2468, 16'h9BDF, 1'b0);

        // LRCK edge aligned with a BCLK rise.
        frame(16'hC001, 16'h3C3C, 1'b1);
        frame(16'h8001, 16'hC001, 1'b1);

        repeat (6) begin
            a = 16'($urandom);
            b = 16'($urandom);
            frame(a, b, 1'($urandom_range(0, 1)));
        end

        a = 16'($urandom);
        b = 16'($urandom);
        n = $urandom_range(1, DW - 1);
        channel(1'b0, a, n, 1'b0);
        channel(1'b1, b, DW, 1'b0);
        a = 16'($urandom);
        b = 16'($urandom);
        frame(a, b, 1'b0);
        frame(b, a, 1'b0);

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        check("drain_queue", 32'(q.size()), 32'h0);
        repeat (50) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
